im_fetch_queue: RTL and testbench
=================================

Name: im_fetch_queue

Overview:
- Instruction-side consumer of the program counter. It owns the fetch PC, issues word-aligned read requests to instruction memory over a valid/ready channel, and reorders nothing: responses return in order.
- Returned instructions are buffered together with their PC in a small queue and handed to decode over a valid/ready channel.
- A redirect (branch/jump) flushes the queue and silently drops any responses still in flight.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_3000, fetch PC loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  load a new fetch PC and flush.
- redirect_pc  in  32  target PC; bits [1:0] are ignored and forced to 0.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  read data valid. Always accepted; no ready signal.
- imem_rsp_data  in  32  instruction word.
- out_valid  out  1  head entry holds an instruction.
- out_ready  in  1  decode consumes the head.
- out_instr  out  32  head instruction.
- out_pc  out  32  PC of the head instruction.

Behaviour:
- Reset (reset=0, async):
  - fetch_pc = RESET_PC; queue empty; alloc, fill and head pointers = 0; drop_cnt = 0.
  - imem_req_valid=0, out_valid=0, out_instr=0, out_pc=0.
- Entry lifecycle: each entry holds {pc, instr, filled}.
  - Allocate: on request handshake (imem_req_valid & imem_req_ready), the entry at the alloc pointer gets pc = fetch_pc and filled = 0. Then alloc pointer +1 and fetch_pc += 4.
  - Fill: on imem_rsp_valid with drop_cnt == 0, the entry at the fill pointer gets instr = imem_rsp_data and filled = 1. Then fill pointer +1.
  - Pop: on out_valid & out_ready, head pointer +1.
- Request rule: imem_req_valid = (allocated count < DEPTH) & ~redirect_valid & (drop_cnt == 0). imem_req_addr = fetch_pc. The count includes unfilled entries, so a response always has a slot.
- Output: out_valid = head entry allocated & filled. out_instr and out_pc come from the head entry (registered storage, no combinational path from imem_rsp_data).
- Minimum latency: response in cycle N gives out_valid in cycle N+1.
- Full/empty: pointers are log2(DEPTH)+1 bits wide.
  - Full: alloc and head differ only in the MSB.
  - Empty: alloc == head.
  - Pointers wrap silently modulo 2*DEPTH.
- fetch_pc wraps 32'hFFFF_FFFC -> 0, with no error.
- Redirect (takes priority over everything in the same cycle):
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - All entries invalidated; pointers reset.
  - No request is issued that cycle.
  - A pop in the same cycle is discarded (out_valid is still shown, but the flush wins).
  - drop_cnt <= (allocated-unfilled count) − (1 if imem_rsp_valid this cycle and that response would otherwise fill).
- Drop: while drop_cnt > 0, each imem_rsp_valid decrements drop_cnt and its data is discarded.
- Back-to-back redirects accumulate correctly: the new drop_cnt is the old drop_cnt plus outstanding unfilled, minus any response consumed this cycle.
- Simultaneous allocate, fill and pop in one cycle are all legal and update independently.
- Protocol error: a response arriving when no unfilled entry exists and drop_cnt == 0 is ignored. Verification flags it with an assertion.
- Reset asserted mid-operation returns everything to the reset values immediately. In-flight memory responses after reset release are the memory's responsibility; the memory is reset by the same signal.

Decomposition:
- Shared package holds:
  - the RESET_PC constant (32'h0000_3000, also used by the NPC logic);
  - the instruction word width (32);
  - the word-step constant (4).
- One natural sub-module: fetch_entry_ram, a DEPTH-entry storage of {pc, instr} with independent alloc-write, fill-write and head-read ports. Pointer, counter and drop logic stay in the top.

Test Plan:
- Reset then release, memory always ready with 1-cycle response:
  - Expected: requests to 0x3000, 0x3004, 0x3008, … on consecutive cycles.
  - Expected: out_pc/out_instr match in order; out_valid first asserts 2 cycles after the first request.
- out_ready held 0 with DEPTH=4: exactly 4 requests issue, then imem_req_valid=0. Raising out_ready for 1 cycle allows exactly 1 new request.
- Responses delayed 3 cycles, redirect to 0x3400 while 2 are outstanding:
  - Expected: both late responses are dropped (out_valid stays 0).
  - Expected: the next request address is 0x3400 and the first out_pc is 0x3400.
- Redirect to 0x3102 in the same cycle as a response and a pop:
  - Expected: the response is dropped and nothing is delivered.
  - Expected: the next request address is 0x3100.
- Fetch from 0xFFFF_FFF8: the address sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset while the queue holds 3 filled entries: out_valid=0 in the same cycle (async); after release, the first request address is 0x3000.

Source files
------------

// File: rtl/im_fetch_queue_pkg.sv
// Shared constants and the queue entry layout for the instruction fetch queue.
package im_fetch_queue_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] WORD_STEP    = 32'd4;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/im_fetch_queue_if.sv
// Redirect, instruction-memory and decode-side handshake bundle of the fetch queue.
interface im_fetch_queue_if;
    import im_fetch_queue_pkg::*;

    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [31:0]        imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [31:0]        out_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
    );

endinterface

// File: rtl/im_fetch_queue_fetch_entry_ram.sv
// DEPTH-entry {pc, instr} store: pc written at allocation, instr at fill, head read combinationally.
module fetch_entry_ram
    import im_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_alloc_we,
    input  logic [$clog2(DEPTH)-1:0]   i_alloc_idx,
    input  logic [31:0]                i_alloc_pc,
    input  logic                       i_fill_we,
    input  logic [$clog2(DEPTH)-1:0]   i_fill_idx,
    input  logic [INSTR_W-1:0]         i_fill_instr,
    input  logic [$clog2(DEPTH)-1:0]   i_head_idx,
    output fq_entry_t                  o_head
);

    fq_entry_t [DEPTH-1:0] r_mem;

    // The two write ports touch disjoint fields, so they may hit the same entry safely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem <= '0;
        end else begin
            if (i_alloc_we) r_mem[i_alloc_idx].pc    <= i_alloc_pc;
            if (i_fill_we)  r_mem[i_fill_idx].instr  <= i_fill_instr;
        end
    end

    assign o_head = r_mem[i_head_idx];

endmodule

// File: rtl/im_fetch_queue.sv
// Fetch PC owner: issues in-order word reads, buffers {pc, instr} for decode, flushes on redirect
// and discards responses that were in flight when the flush happened.
module im_fetch_queue
    import im_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    im_fetch_queue_if.master   fq
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] r_alloc_ptr, r_fill_ptr, r_head_ptr, r_drop_cnt;
    logic [31:0]   r_fetch_pc;

    logic [PW-1:0] w_unfilled, w_drop_nxt;
    logic          w_full, w_drop_act, w_req_fire, w_fill, w_pop, w_rsp_take;
    fq_entry_t     w_head;

    assign w_unfilled = r_alloc_ptr - r_fill_ptr;
    assign w_full     = (r_alloc_ptr[PW-1] != r_head_ptr[PW-1]) &&
                        (r_alloc_ptr[IW-1:0] == r_head_ptr[IW-1:0]);
    assign w_drop_act = (r_drop_cnt != '0);

    assign fq.imem_req_valid = reset && !w_full && !fq.redirect_valid && !w_drop_act;
    assign fq.imem_req_addr  = r_fetch_pc;
    assign w_req_fire        = fq.imem_req_valid && fq.imem_req_ready;

    assign w_fill     = fq.imem_rsp_valid && !w_drop_act && (w_unfilled != '0);
    // A response is "used up" either by a pending drop or by an unfilled slot.
    assign w_rsp_take = fq.imem_rsp_valid && (w_drop_act || (w_unfilled != '0));
    assign w_drop_nxt = r_drop_cnt + w_unfilled - PW'(w_rsp_take);

    assign fq.out_valid = (r_fill_ptr != r_head_ptr);
    assign w_pop        = fq.out_valid && fq.out_ready;
    assign fq.out_pc    = w_head.pc;
    assign fq.out_instr = w_head.instr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc  <= RESET_PC;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_drop_cnt  <= '0;
        end else if (fq.redirect_valid) begin
            r_fetch_pc  <= fq.redirect_pc & ~32'h3;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_drop_cnt  <= w_drop_nxt;
        end else begin
            if (w_req_fire) begin
                r_alloc_ptr <= r_alloc_ptr + PW'(1);
                r_fetch_pc  <= r_fetch_pc + WORD_STEP;
            end
            if (w_fill)                           r_fill_ptr <= r_fill_ptr + PW'(1);
            if (w_pop)                            r_head_ptr <= r_head_ptr + PW'(1);
            if (fq.imem_rsp_valid && w_drop_act)  r_drop_cnt <= r_drop_cnt - PW'(1);
        end
    end

    fetch_entry_ram #(.DEPTH(DEPTH)) u_ram (
        .clk          (clk),
        .reset        (reset),
        .i_alloc_we   (w_req_fire),
        .i_alloc_idx  (r_alloc_ptr[IW-1:0]),
        .i_alloc_pc   (r_fetch_pc),
        .i_fill_we    (w_fill && !fq.redirect_valid),
        .i_fill_idx   (r_fill_ptr[IW-1:0]),
        .i_fill_instr (fq.imem_rsp_data),
        .i_head_idx   (r_head_ptr[IW-1:0]),
        .o_head       (w_head)
    );

    // A response with nothing outstanding and nothing to drop is a memory protocol error.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset)
        !(fq.imem_rsp_valid && !w_drop_act && (w_unfilled == '0)));

endmodule

// File: tb/tb_im_fetch_queue.sv
// Bench for im_fetch_queue: in-order memory model, queue-level reference model, directed table and corners.
module tb_im_fetch_queue;
    import im_fetch_queue_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] SALT  = 32'h5A5A_1234;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    im_fetch_queue_if fq();

    im_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];
    int    lat = 1;
    bit    mem_jitter = 1'b0;

    typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
    ent_t        q[$];
    logic [31:0] m_pc;
    int          m_drop;

    typedef struct {
        bit rr; bit orr; bit redir; logic [31:0] rpc;
        bit e_rv; logic [31:0] e_addr; bit e_ov; logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_pc   = 32'h0000_3000;
        m_drop = 0;
        q.delete();
        pend.delete();
    endfunction

    // Reference: FIFO of {pc, instr, filled}; outputs and next state from the queue contents.
    task automatic model_step();
        bit e_rv, e_ov, done;
        int unf;
        e_rv = (q.size() < DEPTH) && !fq.redirect_valid && (m_drop == 0);
        e_ov = (q.size() > 0) && q[0].filled;
        chk("model_req_valid", 32'(fq.imem_req_valid), 32'(e_rv));
        chk("model_req_addr", fq.imem_req_addr, m_pc);
        chk("model_out_valid", 32'(fq.out_valid), 32'(e_ov));
        if (e_ov) begin
            chk("model_out_pc", fq.out_pc, q[0].pc);
            chk("model_out_instr", fq.out_instr, q[0].instr);
        end
        unf = 0;
        foreach (q[i]) if (!q[i].filled) unf++;
        if (fq.redirect_valid) begin
            m_drop = m_drop + unf - ((fq.imem_rsp_valid && (m_drop > 0 || unf > 0)) ? 1 : 0);
            q.delete();
            m_pc = fq.redirect_pc & ~32'h3;
        end else begin
            if (e_ov && fq.out_ready) q.delete(0);
            if (fq.imem_rsp_valid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    done = 1'b0;
                    for (int i = 0; i < q.size(); i++)
                        if (!done && !q[i].filled) begin
                            q[i].filled = 1'b1;
                            q[i].instr  = fq.imem_rsp_data;
                            done        = 1'b1;
                        end
                end
            end
            if (e_rv && fq.imem_req_ready) begin
                q.push_back('{m_pc, 32'h0, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One clock: memory drives its response, model checks at the falling edge, then advance.
    task automatic cycle();
        if (pend.size() > 0 && pend[0].due <= cyc && (!mem_jitter || $urandom_range(0, 3) != 0)) begin
            fq.imem_rsp_valid = 1'b1;
            fq.imem_rsp_data  = pend[0].addr ^ SALT;
        end else begin
            fq.imem_rsp_valid = 1'b0;
            fq.imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        model_step();
        if (fq.imem_req_valid && fq.imem_req_ready)
            pend.push_back('{fq.imem_req_addr, cyc + (mem_jitter ? int'($urandom_range(1, 4)) : lat)});
        if (fq.imem_rsp_valid) pend.delete(0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fq.redirect_valid = 1'b0;
        fq.redirect_pc    = 32'h0;
        fq.imem_req_ready = 1'b0;
        fq.imem_rsp_valid = 1'b0;
        fq.imem_rsp_data  = 32'h0;
        fq.out_ready      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(fq.imem_req_valid), 32'h0);
        chk("rst_out_valid", 32'(fq.out_valid), 32'h0);
        chk("rst_out_pc", fq.out_pc, 32'h0);
        chk("rst_out_instr", fq.out_instr, 32'h0);
        reset = 1'b1;
    endtask

    task automatic wait_first_out(input string name, input logic [31:0] exp_pc);
        int n;
        n = 0;
        while (!fq.out_valid && n < 20) begin
            cycle();
            #1;
            n++;
        end
        chk({name, "_seen"}, 32'(fq.out_valid), 32'h1);
        chk({name, "_pc"}, fq.out_pc, exp_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_seq [3];

        tbl[0]  = '{1, 1, 0, 32'h0, 1, 32'h3000, 0, 32'h0};
        tbl[1]  = '{1, 1, 0, 32'h0, 1, 32'h3004, 0, 32'h0};
        tbl[2]  = '{1, 1, 0, 32'h0, 1, 32'h3008, 1, 32'h3000};
        tbl[3]  = '{1, 1, 0, 32'h0, 1, 32'h300C, 1, 32'h3004};
        tbl[4]  = '{1, 0, 0, 32'h0, 1, 32'h3010, 1, 32'h3008};
        tbl[5]  = '{1, 0, 0, 32'h0, 1, 32'h3014, 1, 32'h3008};
        tbl[6]  = '{1, 0, 0, 32'h0, 0, 32'h3018, 1, 32'h3008};
        tbl[7]  = '{1, 1, 0, 32'h0, 0, 32'h3018, 1, 32'h3008};
        tbl[8]  = '{1, 0, 0, 32'h0, 1, 32'h3018, 1, 32'h300C};
        tbl[9]  = '{1, 0, 0, 32'h0, 0, 32'h301C, 1, 32'h300C};
        tbl[10] = '{1, 1, 1, 32'h3102, 0, 32'h301C, 1, 32'h300C};
        tbl[11] = '{1, 1, 0, 32'h0, 1, 32'h3100, 0, 32'h0};
        tbl[12] = '{1, 1, 0, 32'h0, 1, 32'h3104, 0, 32'h0};
        tbl[13] = '{1, 1, 0, 32'h0, 1, 32'h3108, 1, 32'h3100};

        // Directed table: streaming, backpressure to full, one-slot release, redirect.
        lat = 1;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            fq.imem_req_ready = tbl[i].rr;
            fq.out_ready      = tbl[i].orr;
            fq.redirect_valid = tbl[i].redir;
            fq.redirect_pc    = tbl[i].rpc;
            #1;
            chk($sformatf("tbl%0d_req_valid", i), 32'(fq.imem_req_valid), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_req_addr", i), fq.imem_req_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_out_valid", i), 32'(fq.out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_out_pc", i), fq.out_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_out_instr", i), fq.out_instr, tbl[i].e_pc ^ SALT);
            end
            cycle();
        end
        fq.redirect_valid = 1'b0;

        // Redirect with two late responses outstanding: both dropped.
        lat = 3;
        do_reset();
        fq.imem_req_ready = 1'b1;
        fq.out_ready      = 1'b1;
        cycle();
        cycle();
        fq.redirect_valid = 1'b1;
        fq.redirect_pc    = 32'h3400;
        cycle();
        fq.redirect_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("drop_req_blocked", 32'(fq.imem_req_valid), 32'h0);
            chk("drop_out_valid", 32'(fq.out_valid), 32'h0);
            cycle();
        end
        #1;
        chk("drop_next_req", 32'(fq.imem_req_valid), 32'h1);
        chk("drop_next_addr", fq.imem_req_addr, 32'h3400);
        wait_first_out("drop_first_out", 32'h3400);

        // Redirect coinciding with a response and a pop.
        lat = 1;
        do_reset();
        fq.imem_req_ready = 1'b1;
        fq.out_ready      = 1'b1;
        cycle();
        cycle();
        fq.redirect_valid = 1'b1;
        fq.redirect_pc    = 32'h3102;
        #1;
        chk("coll_out_valid", 32'(fq.out_valid), 32'h1);
        chk("coll_out_pc", fq.out_pc, 32'h3000);
        cycle();
        fq.redirect_valid = 1'b0;
        #1;
        chk("coll_after_out_valid", 32'(fq.out_valid), 32'h0);
        chk("coll_next_addr", fq.imem_req_addr, 32'h3100);
        wait_first_out("coll_first_out", 32'h3100);

        // Fetch PC wrap at the top of the address space.
        do_reset();
        wrap_seq[0] = 32'hFFFF_FFF8;
        wrap_seq[1] = 32'hFFFF_FFFC;
        wrap_seq[2] = 32'h0000_0000;
        fq.imem_req_ready = 1'b1;
        fq.out_ready      = 1'b1;
        fq.redirect_valid = 1'b1;
        fq.redirect_pc    = 32'hFFFF_FFF8;
        cycle();
        fq.redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("wrap_addr%0d", k), fq.imem_req_addr, wrap_seq[k]);
            cycle();
        end

        // Asynchronous reset with three filled entries held.
        do_reset();
        fq.imem_req_ready = 1'b1;
        fq.out_ready      = 1'b0;
        repeat (3) cycle();
        fq.imem_req_ready = 1'b0;
        repeat (2) cycle();
        #1;
        chk("arst_pre_out_valid", 32'(fq.out_valid), 32'h1);
        chk("arst_pre_count", 32'(q.size()), 32'd3);
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 32'(fq.out_valid), 32'h0);
        chk("arst_req_valid", 32'(fq.imem_req_valid), 32'h0);
        do_reset();
        fq.imem_req_ready = 1'b1;
        #1;
        chk("arst_first_addr", fq.imem_req_addr, 32'h3000);
        chk("arst_first_req", 32'(fq.imem_req_valid), 32'h1);
        cycle();

        // Randomized traffic against the reference model.
        do_reset();
        mem_jitter = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            fq.imem_req_ready = ($urandom_range(0, 3) != 0);
            fq.out_ready      = ($urandom_range(0, 2) != 0);
            fq.redirect_valid = ($urandom_range(0, 29) == 0);
            fq.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                            : (32'h3000 + 32'($urandom_range(0, 1023)));
            cycle();
        end
        fq.redirect_valid = 1'b0;
        mem_jitter = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
